// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
// Eight 4-byte lines; misses refill (and first write back dirty victims) via a block handshake.
module dcache_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             READ,
  input  logic             WRITE,
  input  logic [7:0]       ADDRESS,
  input  logic [7:0]       WRITEDATA,
  output logic [7:0]       READDATA,
  output logic             BUSYWAIT,
  output logic             MEM_READ,
  output logic             MEM_WRITE,
  output logic [5:0]       MEM_ADDRESS,
  output logic [31:0]      MEM_WRITEDATA,
  input  logic [31:0]      MEM_READDATA,
  input  logic             MEM_BUSYWAIT,
  output logic [CNT_W-1:0] HIT_COUNT,
  output logic [CNT_W-1:0] MISS_COUNT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_next;
  logic [7:0]  valid, dirty;
  logic [2:0]  tag_arr  [8];
  logic [31:0] data_arr [8];
  logic        settled;
  logic [7:0]  rd_hold;

  logic [2:0]  idx, tag_in;
  logic [1:0]  off;
  logic        req, hit, mem_done, hit_access;
  logic [31:0] cur_block;
  logic [7:0]  cur_byte;

  assign idx        = ADDRESS[4:2];
  assign tag_in     = ADDRESS[7:5];
  assign off        = ADDRESS[1:0];
  assign req        = READ | WRITE;
  assign hit        = valid[idx] && (tag_arr[idx] == tag_in);
  assign cur_block  = data_arr[idx];
  assign cur_byte   = cur_block[{off, 3'b000} +: 8];
  assign hit_access = (state == IDLE) && req && hit;
  // settled guards against a memory that only raises busy a cycle after the request
  assign mem_done   = settled && !MEM_BUSYWAIT;

  assign MEM_WRITEDATA = cur_block;
  assign READDATA      = hit_access ? cur_byte : rd_hold;

  always_comb begin
    state_next  = state;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = {tag_in, idx};
    BUSYWAIT    = 1'b0;
    case (state)
      IDLE: begin
        BUSYWAIT = req && !hit;
        if (req && !hit) begin
          state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {tag_arr[idx], idx};
        BUSYWAIT    = 1'b1;
        if (mem_done) state_next = FETCH;
      end
      FETCH: begin
        MEM_READ = 1'b1;
        BUSYWAIT = 1'b1;
        if (mem_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      settled <= 1'b0;
    end else begin
      state   <= state_next;
      settled <= (state_next == state) && (state != IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == FETCH && mem_done) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (hit_access && WRITE) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Line contents and tags are left alone by reset; valid alone qualifies them.
  always_ff @(posedge CLK) begin
    if (state == FETCH && mem_done) begin
      data_arr[idx] <= MEM_READDATA;
      tag_arr[idx]  <= tag_in;
    end else if (hit_access && WRITE) begin
      data_arr[idx][{off, 3'b000} +: 8] <= WRITEDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
      rd_hold    <= '0;
    end else begin
      if (hit_access) begin
        rd_hold <= cur_byte;
        if (HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + CNT_ONE;
      end
      if (state == IDLE && req && !hit && MISS_COUNT != '1) begin
        MISS_COUNT <= MISS_COUNT + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed table-driven bench for dcache_controller
// Behavioural 5-cycle block memory, bus monitor and hand-computed expected vectors.
module tb_dcache_controller;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  logic [15:0] HIT_COUNT, MISS_COUNT;

  dcache_controller #(.CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  // Memory holds each request for MEM_LAT cycles; busy is low in the last one.
  localparam int MEM_LAT = 5;
  logic [31:0] mem [64];
  logic        mem_init;
  int          mc = 0;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mc < MEM_LAT - 1);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      end
      mem[1] <= 32'h44332211;
      mc <= 0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (mc == MEM_LAT - 1) begin
        mc <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end else begin
        mc <= mc + 1;
      end
    end else begin
      mc <= 0;
    end
  end

  int          wb_n = 0, fe_n = 0, overlap_n = 0;
  logic [5:0]  wb_addr, fe_addr;
  logic [31:0] wb_data;

  always @(negedge CLK) begin
    if (MEM_READ && MEM_WRITE) overlap_n <= overlap_n + 1;
    if (MEM_WRITE) begin
      wb_n    <= wb_n + 1;
      wb_addr <= MEM_ADDRESS;
      wb_data <= MEM_WRITEDATA;
    end
    if (MEM_READ) begin
      fe_n    <= fe_n + 1;
      fe_addr <= MEM_ADDRESS;
    end
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          busy;
    logic        chk_rd;
    logic [7:0]  rdata;
    int          hits;
    int          misses;
    logic        exp_wb;
    logic [5:0]  wb_a;
    logic [31:0] wb_d;
    logic        exp_fe;
    logic [5:0]  fe_a;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int         busy;
    int         wb0, fe0;
    logic [7:0] rdv;
    string      tg;
    tg = $sformatf("v%0d", id);
    @(negedge CLK);
    wb0 = wb_n;
    fe0 = fe_n;
    READ = v.rd; WRITE = v.wr; ADDRESS = v.addr; WRITEDATA = v.wdata;
    #1;
    busy = 0;
    while (BUSYWAIT && busy < 100) begin
      busy++;
      @(negedge CLK);
      #1;
    end
    rdv = READDATA;
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
    #1;
    check({tg, " busy_cycles"}, busy, v.busy);
    if (v.chk_rd) check({tg, " readdata"}, rdv, v.rdata);
    check({tg, " hit_count"}, HIT_COUNT, v.hits);
    check({tg, " miss_count"}, MISS_COUNT, v.misses);
    check({tg, " writeback_seen"}, (wb_n != wb0), v.exp_wb);
    if (v.exp_wb) begin
      check({tg, " wb_addr"}, wb_addr, v.wb_a);
      check({tg, " wb_data"}, wb_data, v.wb_d);
    end
    check({tg, " fetch_seen"}, (fe_n != fe0), v.exp_fe);
    if (v.exp_fe) check({tg, " fetch_addr"}, fe_addr, v.fe_a);
    check({tg, " rd_wr_overlap"}, overlap_n, 0);
  endtask

  vec_t vecs [9];
  vec_t v;
  int   waited;

  initial begin
    //            wr rd addr   wdata busy chk rdata hit mis wb wb_a   wb_d          fe fe_a
    vecs[0] = '{1'b0, 1'b1, 8'h05, 8'h00,  6, 1'b1, 8'h22, 1, 1, 1'b0, 6'h00, 32'h0,        1'b1, 6'h01};
    vecs[1] = '{1'b1, 1'b0, 8'h06, 8'hAB,  0, 1'b0, 8'h00, 2, 1, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
    vecs[2] = '{1'b0, 1'b1, 8'h06, 8'h00,  0, 1'b1, 8'hAB, 3, 1, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
    vecs[3] = '{1'b0, 1'b1, 8'h25, 8'h00, 11, 1'b1, 8'h25, 4, 2, 1'b1, 6'h01, 32'h44AB2211, 1'b1, 6'h09};
    vecs[4] = '{1'b0, 1'b1, 8'h04, 8'h00,  6, 1'b1, 8'h11, 5, 3, 1'b0, 6'h00, 32'h0,        1'b1, 6'h01};
    vecs[5] = '{1'b1, 1'b0, 8'h1F, 8'h77,  6, 1'b0, 8'h00, 6, 4, 1'b0, 6'h00, 32'h0,        1'b1, 6'h07};
    vecs[6] = '{1'b0, 1'b1, 8'h1F, 8'h00,  0, 1'b1, 8'h77, 7, 4, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
    vecs[7] = '{1'b0, 1'b1, 8'h1C, 8'h00,  0, 1'b1, 8'h1C, 8, 4, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00};
    vecs[8] = '{1'b0, 1'b1, 8'hFF, 8'h00, 11, 1'b1, 8'hFF, 9, 5, 1'b1, 6'h07, 32'h771E1D1C, 1'b1, 6'h3F};

    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    mem_init = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0; mem_init = 1'b0;
    #1;
    check("rst busywait", BUSYWAIT, 0);
    check("rst readdata", READDATA, 0);
    check("rst mem_read", MEM_READ, 0);
    check("rst mem_write", MEM_WRITE, 0);
    check("rst hit_count", HIT_COUNT, 0);
    check("rst miss_count", MISS_COUNT, 0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
    check("hold readdata after miss", READDATA, 8'hFF);

    // Abort a clean refill of 0x45 with reset part-way through FETCH.
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h45;
    #1;
    check("miss stalls", BUSYWAIT, 1);
    waited = 0;
    while (!MEM_READ && waited < 20) begin
      waited++;
      @(negedge CLK);
      #1;
    end
    check("fetch started", MEM_READ, 1);
    repeat (2) @(negedge CLK);
    RESET = 1'b1; READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("abort mem_read", MEM_READ, 0);
    check("abort mem_write", MEM_WRITE, 0);
    check("abort busywait", BUSYWAIT, 0);
    check("abort hit_count", HIT_COUNT, 0);
    check("abort miss_count", MISS_COUNT, 0);
    check("abort readdata", READDATA, 0);

    v = '{1'b0, 1'b1, 8'h05, 8'h00, 6, 1'b1, 8'h22, 1, 1, 1'b0, 6'h00, 32'h0, 1'b1, 6'h01};
    run_vec(9, v);
    v = '{1'b1, 1'b1, 8'h06, 8'h5C, 0, 1'b0, 8'h00, 2, 1, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00};
    run_vec(10, v);
    v = '{1'b0, 1'b1, 8'h06, 8'h00, 0, 1'b1, 8'h5C, 3, 1, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00};
    run_vec(11, v);

    // Hold a hit long enough to saturate the 16-bit hit counter.
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h06;
    repeat (70000) @(negedge CLK);
    READ = 1'b0;
    #1;
    check("sat hit_count", HIT_COUNT, 16'hFFFF);
    check("sat miss_count", MISS_COUNT, 1);
    check("sat busywait", BUSYWAIT, 0);
    check("sat readdata hold", READDATA, 8'h5C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
